ctrl_pipeline: RTL and testbench
================================

# ctrl_pipeline

Pipeline control block that consumes the main decoder's 9-bit control bundle in the ID stage and carries it through the ID/EX, EX/MEM and MEM/WB registers to the stages that act on it. It also resolves data hazards (stall or forward) and control hazards (flush on taken branch). It sits between the main decoder and the 5-stage datapath, and is the sole source of per-stage control, `stall` and `flush_ifid`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `id_valid`  in  1  IF/ID holds a real instruction
- `id_ctrl`  in  9  `{RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, AluOP[1:0]}`, MSB first, from the decoder
- `id_rs`, `id_rt`, `id_rd`  in  5 each  ID-stage register fields
- `br_taken`  in  1  datapath branch condition true for the EX instruction
- `ex_alusrc`  out  1  EX-stage ALUSrc
- `ex_aluop`  out  2  EX-stage AluOP
- `mem_read`, `mem_write`  out  1 each  MEM-stage controls
- `wb_memtoreg`, `wb_regwrite`  out  1 each  WB-stage controls
- `wb_wreg`  out  5  WB destination register
- `stall`  out  1  hold PC and IF/ID
- `flush_ifid`  out  1  squash IF/ID
- `fwd_a`, `fwd_b`  out  2 each  EX operand select; present only with `CTRL_FORWARD_EN`

## Operation
- ID/EX, EX/MEM and MEM/WB advance every cycle; there is no back-pressure.
- ID/EX load: the register takes the bubble (all control 0, wreg 0) if `!id_valid`, `stall` or `flush_ifid`. Otherwise it takes `id_ctrl`, `id_rs` and `id_rt`, with `wreg = RegDst ? id_rd : id_rt`.
- Register-write qualification: a stage "writes R" when its RegWrite = 1, its wreg = R, and R != 0. Decoder don't-cares on non-writing opcodes are masked by RegWrite, i.e. `load = MemRead & RegWrite`.
- Branch: `flush_ifid = br_taken & ex_Branch`. Flush forces `stall = 0`; flush has priority over stall.
- Hazard matching is conservative: both `id_rs` and `id_rt` are always compared.
- The register file writes in the first half of the cycle, so the WB stage never causes a hazard.

## Timing
- An instruction accepted in ID in cycle n drives EX outputs in n+1, MEM outputs in n+2 and WB outputs in n+3.
- `stall`, `flush_ifid` and `fwd_*` are combinational from the pipeline registers and the ID inputs, valid in the same cycle.
- Reset is asynchronous: all pipeline registers clear to bubble, so every output is 0, including `stall`, `flush_ifid` and `fwd_*`. A reset mid-stream discards all in-flight instructions.
- `stall` lasts exactly as long as the hazard condition holds, re-evaluated every cycle.
- If a flush and a hazard occur in the same cycle, the flush is taken and there is no stall.

## Configuration
- **`CTRL_FORWARD_EN` defined:**
  - `ex_rs` and `ex_rt` are stored in ID/EX.
  - `fwd_a` = 2'b10 if EX/MEM writes `ex_rs`; else 2'b01 if MEM/WB writes `ex_rs`; else 2'b00. EX/MEM has priority. `fwd_b` is the same using `ex_rt`.
  - `stall` = 1 only on load-use: the ID/EX `load` writes `id_rs` or `id_rt`. This gives a 1-cycle stall.
- **`CTRL_FORWARD_EN` undefined:**
  - The `fwd_*` ports are absent.
  - `stall` = 1 when ID/EX or EX/MEM writes `id_rs` or `id_rt`. This gives up to 2 stall cycles per RAW hazard.

## Test plan
- Reset asserted mid-stream with 3 instructions in flight -> all outputs 0 immediately; first new instruction reaches WB 3 cycles after release.
- FORWARD_EN, `add r3,r1,r2` then `add r4,r3,r3` back-to-back -> no stall; `fwd_a = fwd_b = 10` while the second add is in EX; a third `add r5,r3,r0` gets `fwd_a = 01`.
- FORWARD_EN, `lw r5,0(r1)` then `add r6,r5,r2` -> `stall` = 1 for 1 cycle; EX holds a bubble (`ex_aluop = 0`); the add then enters EX with `fwd_a = 01`.
- No FORWARD_EN, `add r3,...` then `add r4,r3,r0` -> `stall` = 1 for 2 cycles; add reaches EX the cycle after the producer enters WB.
- `beq` in EX with `br_taken` = 1 while ID holds a load-use hazard -> `flush_ifid` = 1, `stall` = 0; next cycle EX is a bubble.
- `addi r0,r0,5` followed by `add r1,r0,r0` -> no stall, `fwd_a = fwd_b = 00`.

Source files
------------

// File: rtl/ctrl_pipeline.sv
// Per-stage control for a 5-stage pipeline: carries decoder control through ID/EX, EX/MEM, MEM/WB
// and resolves data/control hazards. Define CTRL_FORWARD_EN to add EX operand forwarding.
module ctrl_pipeline (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [8:0] id_ctrl,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       br_taken,
    output logic       ex_alusrc,
    output logic [1:0] ex_aluop,
    output logic       mem_read,
    output logic       mem_write,
    output logic       wb_memtoreg,
    output logic       wb_regwrite,
    output logic [4:0] wb_wreg,
    output logic       stall,
    output logic       flush_ifid
`ifdef CTRL_FORWARD_EN
    ,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
`endif
);

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
        logic [4:0] wreg;
`ifdef CTRL_FORWARD_EN
        logic [4:0] rs;
        logic [4:0] rt;
`endif
    } idex_t;

    typedef struct packed {
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [4:0] wreg;
    } exmem_t;

    typedef struct packed {
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] wreg;
    } memwb_t;

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    logic   hazard;

    // r0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic writes(input logic regwrite, input logic [4:0] wreg,
                                    input logic [4:0] r);
        return regwrite && (wreg == r) && (r != 5'd0);
    endfunction

    always_comb begin
        flush_ifid = br_taken & idex_q.branch;
`ifdef CTRL_FORWARD_EN
        hazard = idex_q.memread & (writes(idex_q.regwrite, idex_q.wreg, id_rs) |
                                   writes(idex_q.regwrite, idex_q.wreg, id_rt));
`else
        hazard = writes(idex_q.regwrite, idex_q.wreg, id_rs) |
                 writes(idex_q.regwrite, idex_q.wreg, id_rt) |
                 writes(exmem_q.regwrite, exmem_q.wreg, id_rs) |
                 writes(exmem_q.regwrite, exmem_q.wreg, id_rt);
`endif
        stall = hazard & ~flush_ifid;
    end

    always_comb begin
        idex_d = '0;
        if (id_valid && !stall && !flush_ifid) begin
            idex_d.alusrc   = id_ctrl[7];
            idex_d.memtoreg = id_ctrl[6];
            idex_d.regwrite = id_ctrl[5];
            idex_d.memread  = id_ctrl[4];
            idex_d.memwrite = id_ctrl[3];
            idex_d.branch   = id_ctrl[2];
            idex_d.aluop    = id_ctrl[1:0];
            idex_d.wreg     = id_ctrl[8] ? id_rd : id_rt;
`ifdef CTRL_FORWARD_EN
            idex_d.rs       = id_rs;
            idex_d.rt       = id_rt;
`endif
        end
    end

    always_comb begin
        exmem_d.memtoreg = idex_q.memtoreg;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memread  = idex_q.memread;
        exmem_d.memwrite = idex_q.memwrite;
        exmem_d.wreg     = idex_q.wreg;
        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.wreg     = exmem_q.wreg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

`ifdef CTRL_FORWARD_EN
    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        fwd_a = 2'b00;
        if (writes(exmem_q.regwrite, exmem_q.wreg, idex_q.rs))      fwd_a = 2'b10;
        else if (writes(memwb_q.regwrite, memwb_q.wreg, idex_q.rs)) fwd_a = 2'b01;
        fwd_b = 2'b00;
        if (writes(exmem_q.regwrite, exmem_q.wreg, idex_q.rt))      fwd_b = 2'b10;
        else if (writes(memwb_q.regwrite, memwb_q.wreg, idex_q.rt)) fwd_b = 2'b01;
    end
`endif

    assign ex_alusrc   = idex_q.alusrc;
    assign ex_aluop    = idex_q.aluop;
    assign mem_read    = exmem_q.memread;
    assign mem_write   = exmem_q.memwrite;
    assign wb_memtoreg = memwb_q.memtoreg;
    assign wb_regwrite = memwb_q.regwrite;
    assign wb_wreg     = memwb_q.wreg;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed hazard scenarios plus random traffic against an
// instruction-level model of the in-flight pipeline. Honours CTRL_FORWARD_EN.
module tb_ctrl_pipeline;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [8:0] id_ctrl;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       br_taken;
    logic       ex_alusrc;
    logic [1:0] ex_aluop;
    logic       mem_read, mem_write, wb_memtoreg, wb_regwrite;
    logic [4:0] wb_wreg;
    logic       stall, flush_ifid;
`ifdef CTRL_FORWARD_EN
    logic [1:0] fwd_a, fwd_b;
`endif

    ctrl_pipeline dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_ctrl    (id_ctrl),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .br_taken   (br_taken),
        .ex_alusrc  (ex_alusrc),
        .ex_aluop   (ex_aluop),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .wb_memtoreg(wb_memtoreg),
        .wb_regwrite(wb_regwrite),
        .wb_wreg    (wb_wreg),
        .stall      (stall),
        .flush_ifid (flush_ifid)
`ifdef CTRL_FORWARD_EN
        ,
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       alusrc, memtoreg, regwrite, memread, memwrite, branch;
        logic [1:0] aluop;
        logic [4:0] wreg, rs, rt;
    } ins_t;

    localparam logic [8:0] ADD  = 9'b100100010;
    localparam logic [8:0] LW   = 9'b011110000;
    localparam logic [8:0] BEQ  = 9'b000000101;
    localparam logic [8:0] ADDI = 9'b010100000;

    ins_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
    int   checks = 0;
    int   failures = 0;
    logic exp_st, exp_fl;

    function automatic ins_t bubble();
        ins_t b;
        b = '{alusrc: 1'b0, memtoreg: 1'b0, regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0,
              branch: 1'b0, aluop: 2'b00, wreg: 5'd0, rs: 5'd0, rt: 5'd0};
        return b;
    endfunction

    function automatic ins_t decode(logic [8:0] c, logic [4:0] rs, logic [4:0] rt,
                                    logic [4:0] rd);
        ins_t i;
        i = '{alusrc: c[7], memtoreg: c[6], regwrite: c[5], memread: c[4], memwrite: c[3],
              branch: c[2], aluop: c[1:0], wreg: (c[8] ? rd : rt), rs: rs, rt: rt};
        return i;
    endfunction

    function automatic bit wr(ins_t s, logic [4:0] r);
        return s.regwrite && s.wreg == r && r != 5'd0;
    endfunction

    function automatic bit model_hazard();
        bit h = 0;
`ifdef CTRL_FORWARD_EN
        h = pipe[0].memread && (wr(pipe[0], id_rs) || wr(pipe[0], id_rt));
`else
        for (int s = 0; s < 2; s++) h = h || wr(pipe[s], id_rs) || wr(pipe[s], id_rt);
`endif
        return h;
    endfunction

    function automatic logic [1:0] model_fwd(logic [4:0] r);
        if (wr(pipe[1], r)) return 2'b10;
        if (wr(pipe[2], r)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(string tag, logic [4:0] obs, logic [4:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 3; s++) pipe[s] = bubble();
    endtask

    task automatic check_all();
        exp_fl = br_taken && pipe[0].branch;
        exp_st = model_hazard() && !exp_fl;
        chk("ex_alusrc",   5'(ex_alusrc),   5'(pipe[0].alusrc));
        chk("ex_aluop",    5'(ex_aluop),    5'(pipe[0].aluop));
        chk("mem_read",    5'(mem_read),    5'(pipe[1].memread));
        chk("mem_write",   5'(mem_write),   5'(pipe[1].memwrite));
        chk("wb_memtoreg", 5'(wb_memtoreg), 5'(pipe[2].memtoreg));
        chk("wb_regwrite", 5'(wb_regwrite), 5'(pipe[2].regwrite));
        chk("wb_wreg",     wb_wreg,         pipe[2].wreg);
        chk("stall",       5'(stall),       5'(exp_st));
        chk("flush_ifid",  5'(flush_ifid),  5'(exp_fl));
`ifdef CTRL_FORWARD_EN
        chk("fwd_a", 5'(fwd_a), 5'(model_fwd(pipe[0].rs)));
        chk("fwd_b", 5'(fwd_b), 5'(model_fwd(pipe[0].rt)));
`endif
    endtask

    task automatic drive(logic v, logic [8:0] c, logic [4:0] rs, logic [4:0] rt,
                         logic [4:0] rd, logic br);
        @(negedge clk);
        id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; br_taken = br;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            clear_model();
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (id_valid && !exp_st && !exp_fl) ? decode(id_ctrl, id_rs, id_rt, id_rd)
                                                      : bubble();
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 1'b0; id_ctrl = 9'd0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        br_taken = 1'b0;
        clear_model();
        drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("reset_stall", 5'(stall), 5'd0);
        tick();
        #2 reset = 1'b0;

        // add r3,r1,r2 ; add r4,r3,r3 ; add r5,r3,r0
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("raw_first_stall", 5'(stall), 5'd0);
        tick();
        drive(1'b1, ADD, 5'd3, 5'd3, 5'd4, 1'b0);
`ifdef CTRL_FORWARD_EN
        chk("raw_fwd_nostall", 5'(stall), 5'd0);
        tick();
        drive(1'b1, ADD, 5'd3, 5'd0, 5'd5, 1'b0);
        chk("raw_fwd_a_exmem", 5'(fwd_a), 5'd2);
        chk("raw_fwd_b_exmem", 5'(fwd_b), 5'd2);
        tick();
        drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("raw_fwd_a_memwb", 5'(fwd_a), 5'd1);
        tick();
`else
        chk("raw_stall_c1", 5'(stall), 5'd1);
        tick();
        drive(1'b1, ADD, 5'd3, 5'd3, 5'd4, 1'b0);
        chk("raw_stall_c2", 5'(stall), 5'd1);
        tick();
        drive(1'b1, ADD, 5'd3, 5'd3, 5'd4, 1'b0);
        chk("raw_stall_done", 5'(stall), 5'd0);
        chk("raw_producer_wb", wb_wreg, 5'd3);
        tick();
        drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("raw_consumer_ex", 5'(ex_aluop), 5'd2);
        tick();
`endif
        idle(3);

        // lw r5,0(r1) ; add r6,r5,r2
        drive(1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0);
        tick();
        drive(1'b1, ADD, 5'd5, 5'd2, 5'd6, 1'b0);
        chk("lu_stall_c1", 5'(stall), 5'd1);
        tick();
`ifdef CTRL_FORWARD_EN
        drive(1'b1, ADD, 5'd5, 5'd2, 5'd6, 1'b0);
        chk("lu_stall_done", 5'(stall), 5'd0);
        chk("lu_ex_bubble", 5'(ex_aluop), 5'd0);
        tick();
        drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("lu_fwd_a", 5'(fwd_a), 5'd1);
        tick();
`else
        drive(1'b1, ADD, 5'd5, 5'd2, 5'd6, 1'b0);
        chk("lu_stall_c2", 5'(stall), 5'd1);
        tick();
        drive(1'b1, ADD, 5'd5, 5'd2, 5'd6, 1'b0);
        chk("lu_stall_done", 5'(stall), 5'd0);
        tick();
`endif
        idle(3);

        // lw r9 ; beq r1,r2 ; ID add r8,r9,r9 with beq taken in EX
        drive(1'b1, LW, 5'd1, 5'd9, 5'd0, 1'b0);
        tick();
        drive(1'b1, BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        drive(1'b1, ADD, 5'd9, 5'd9, 5'd8, 1'b1);
        chk("br_flush", 5'(flush_ifid), 5'd1);
        chk("br_nostall", 5'(stall), 5'd0);
        tick();
        drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("br_ex_bubble", 5'(ex_aluop), 5'd0);
        tick();
        idle(3);

        // addi r0,r0,5 ; add r1,r0,r0
        drive(1'b1, ADDI, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, ADD, 5'd0, 5'd0, 5'd1, 1'b0);
        chk("r0_nostall", 5'(stall), 5'd0);
        tick();
`ifdef CTRL_FORWARD_EN
        drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("r0_fwd_a", 5'(fwd_a), 5'd0);
        chk("r0_fwd_b", 5'(fwd_b), 5'd0);
        tick();
`endif

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 9'($urandom), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) == 0));
            tick();
        end

        // Reset with three instructions in flight
        idle(3);
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd10, 1'b0); tick();
        drive(1'b1, LW,  5'd1, 5'd11, 5'd0, 1'b0); tick();
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd12, 1'b0); tick();
        @(negedge clk);
        id_valid = 1'b0; id_ctrl = 9'd0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        br_taken = 1'b0;
        reset = 1'b1;
        clear_model();
        #1;
        chk("rst_ex_aluop", 5'(ex_aluop), 5'd0);
        chk("rst_mem_read", 5'(mem_read), 5'd0);
        chk("rst_wb_wreg", wb_wreg, 5'd0);
        chk("rst_wb_regwrite", 5'(wb_regwrite), 5'd0);
        check_all();
        tick();
        #2 reset = 1'b0;
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd13, 1'b0); tick();
        idle(2);
        drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("post_rst_wb_wreg", wb_wreg, 5'd13);
        chk("post_rst_wb_regwrite", 5'(wb_regwrite), 5'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
